// File: rtl/posit_product_pipe_pkg.sv
// Shared posit width helpers and the legacy 32/2 constants.
package posit_product_pipe_pkg;

  function automatic int unsigned fbits(input int unsigned n, input int unsigned es);
    return n - 3 - es;
  endfunction

  function automatic int unsigned mbits(input int unsigned n, input int unsigned es);
    return 2 * (fbits(n, es) + 1);
  endfunction

  function automatic int unsigned sbits(input int unsigned n, input int unsigned es);
    return unsigned'($clog2(n)) + es + 1;
  endfunction

  localparam int unsigned POSIT_NBITS = 32;
  localparam int unsigned POSIT_ES    = 2;
  localparam int unsigned POSIT_FBITS = fbits(POSIT_NBITS, POSIT_ES);
  localparam int unsigned POSIT_MBITS = mbits(POSIT_NBITS, POSIT_ES);
  localparam int unsigned POSIT_SBITS = sbits(POSIT_NBITS, POSIT_ES);

endpackage

// File: rtl/posit_pipe_slice.sv
// One valid/ready register stage; loads when empty or when the next stage loads.
module posit_pipe_slice #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  input  logic             next_load,
  output logic             load_c,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data
);

  logic             valid_q, valid_d;
  logic [WIDTH-1:0] data_q, data_d;

  assign load_c = !valid_q | next_load;

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (load_c) begin
      valid_d = in_valid;
      if (in_valid) data_d = in_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign out_valid = valid_q;
  assign out_data  = data_q;

endmodule

// File: rtl/posit_product_pipe.sv
// Pipelined posit mantissa/scale multiplier with valid/ready flow control.
// Define POSIT_PRODUCT_SAT_EN to clamp the product scale to the maxpos/minpos range.
module posit_product_pipe
  import posit_product_pipe_pkg::*;
#(
  parameter int unsigned NBITS   = 32,
  parameter int unsigned ES      = 2,
  parameter int unsigned LATENCY = 3
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              in_valid,
  output logic                              in_ready,
  input  logic                              a_sign,
  input  logic [sbits(NBITS, ES)-1:0]       a_scale,
  input  logic [fbits(NBITS, ES)-1:0]       a_fraction,
  input  logic                              a_inf,
  input  logic                              a_zero,
  input  logic                              b_sign,
  input  logic [sbits(NBITS, ES)-1:0]       b_scale,
  input  logic [fbits(NBITS, ES)-1:0]       b_fraction,
  input  logic                              b_inf,
  input  logic                              b_zero,
  output logic                              out_valid,
  input  logic                              out_ready,
  output logic                              out_sign,
  output logic [sbits(NBITS, ES):0]         out_scale,
  output logic [((ES > 0) ? ES : 1)-1:0]    out_exponent,
  output logic [mbits(NBITS, ES)-1:0]       out_fraction,
  output logic                              out_inf,
  output logic                              out_zero
);

  localparam int unsigned FBITS  = fbits(NBITS, ES);
  localparam int unsigned FHBITS = FBITS + 1;
  localparam int unsigned MBITS  = mbits(NBITS, ES);
  localparam int unsigned SBITS  = sbits(NBITS, ES);
  localparam int unsigned EW     = (ES > 0) ? ES : 1;
  localparam int unsigned OW     = 2 * (SBITS + FBITS + 3);
  localparam int unsigned PW     = SBITS + 1 + MBITS + 3;

  logic [LATENCY:0]   ld;
  logic [LATENCY-1:0] vld;
  logic [OW-1:0]      s0_q;
  logic [PW-1:0]      st_in [1:LATENCY-1];
  logic [PW-1:0]      st_q  [1:LATENCY-1];

  assign ld[LATENCY] = out_ready;
  assign in_ready    = ld[0] & rst_n;

  posit_pipe_slice #(.WIDTH(OW)) u_slice0 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_data   ({a_sign, a_scale, a_fraction, a_inf, a_zero,
                 b_sign, b_scale, b_fraction, b_inf, b_zero}),
    .next_load (ld[1]),
    .load_c    (ld[0]),
    .out_valid (vld[0]),
    .out_data  (s0_q)
  );

  // Product stage: hidden-bit multiply, scale sum and special resolution
  logic               s0_a_sign, s0_a_inf, s0_a_zero, s0_b_sign, s0_b_inf, s0_b_zero;
  logic [SBITS-1:0]   s0_a_scale, s0_b_scale;
  logic [FBITS-1:0]   s0_a_frac, s0_b_frac;
  logic               p_sign, p_inf, p_zero;
  logic [SBITS:0]     p_scale;
  logic [MBITS-1:0]   p_mant;
  logic [PW-1:0]      prod_pl;

  assign {s0_a_sign, s0_a_scale, s0_a_frac, s0_a_inf, s0_a_zero,
          s0_b_sign, s0_b_scale, s0_b_frac, s0_b_inf, s0_b_zero} = s0_q;

  always_comb begin
    p_inf   = s0_a_inf | s0_b_inf;
    p_zero  = !p_inf & (s0_a_zero | s0_b_zero);
    p_sign  = s0_a_sign ^ s0_b_sign;
    p_scale = {s0_a_scale[SBITS-1], s0_a_scale} + {s0_b_scale[SBITS-1], s0_b_scale};
    p_mant  = MBITS'({1'b1, s0_a_frac}) * MBITS'({1'b1, s0_b_frac});
    if (p_inf | p_zero) begin
      p_sign  = 1'b0;
      p_scale = '0;
      p_mant  = '0;
    end
  end

  assign prod_pl = {p_sign, p_scale, p_mant, p_inf, p_zero};

  // Product lies in [1,4): shift the leading one out and bump scale when >= 2
  function automatic logic [PW-1:0] normalise(input logic [PW-1:0] x);
    logic             sign, inf, zero;
    logic [SBITS:0]   scale;
    logic [MBITS-1:0] mant, frac;
`ifdef POSIT_PRODUCT_SAT_EN
    localparam int unsigned  SAT_LIM   = (NBITS - 2) << ES;
    localparam logic [SBITS:0] SCALE_MAX = (SBITS + 1)'(SAT_LIM);
    localparam logic [SBITS:0] SCALE_MIN = (SBITS + 1)'(-int'(SAT_LIM));
`endif
    {sign, scale, mant, inf, zero} = x;
    if (mant[MBITS-1]) begin
      scale = scale + (SBITS + 1)'(1);
      frac  = {mant[MBITS-2:0], 1'b0};
    end else begin
      frac  = {mant[MBITS-3:0], 2'b00};
    end
`ifdef POSIT_PRODUCT_SAT_EN
    if ($signed(scale) > $signed(SCALE_MAX)) begin
      scale = SCALE_MAX;
      frac  = '0;
    end else if ($signed(scale) < $signed(SCALE_MIN)) begin
      scale = SCALE_MIN;
      frac  = '0;
    end
`endif
    return {sign, scale, frac, inf, zero};
  endfunction

  for (genvar i = 1; i < LATENCY; i++) begin : g_stage
    logic [PW-1:0] base;
    if (i == 1) begin : g_first
      assign base = prod_pl;
    end else begin : g_retime
      assign base = st_q[i-1];
    end
    if (i == LATENCY - 1) begin : g_norm
      assign st_in[i] = normalise(base);
    end else begin : g_pass
      assign st_in[i] = base;
    end
    posit_pipe_slice #(.WIDTH(PW)) u_slice (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (vld[i-1]),
      .in_data   (st_in[i]),
      .next_load (ld[i+1]),
      .load_c    (ld[i]),
      .out_valid (vld[i]),
      .out_data  (st_q[i])
    );
  end

  assign out_valid = vld[LATENCY-1];
  assign {out_sign, out_scale, out_fraction, out_inf, out_zero} = st_q[LATENCY-1];

  if (ES > 0) begin : g_exp
    assign out_exponent = out_scale[EW-1:0];
  end else begin : g_noexp
    assign out_exponent = '0;
  end

endmodule

// File: tb/tb_posit_product_pipe.sv
// Scoreboard bench for posit_product_pipe at NBITS=32, ES=2, LATENCY=3.
module tb_posit_product_pipe;

  localparam int unsigned LATENCY = 3;

  typedef struct {
    logic        sign;
    logic [7:0]  scale;
    logic [26:0] frac;
    logic        inf;
    logic        zero;
  } op_t;

  typedef struct {
    logic        sign;
    logic [8:0]  scale;
    logic [55:0] frac;
    logic        inf;
    logic        zero;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready, out_valid, out_ready;
  logic        a_sign, a_inf, a_zero, b_sign, b_inf, b_zero;
  logic [7:0]  a_scale, b_scale;
  logic [26:0] a_fraction, b_fraction;
  logic        out_sign, out_inf, out_zero;
  logic [8:0]  out_scale;
  logic [1:0]  out_exponent;
  logic [55:0] out_fraction;

  int n_chk  = 0;
  int n_pass = 0;
  int xfer   = 0;
  exp_t sb[$];

  always #5 clk = ~clk;

  posit_product_pipe #(.NBITS(32), .ES(2), .LATENCY(LATENCY)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a_sign(a_sign), .a_scale(a_scale), .a_fraction(a_fraction), .a_inf(a_inf), .a_zero(a_zero),
    .b_sign(b_sign), .b_scale(b_scale), .b_fraction(b_fraction), .b_inf(b_inf), .b_zero(b_zero),
    .out_valid(out_valid), .out_ready(out_ready), .out_sign(out_sign), .out_scale(out_scale),
    .out_exponent(out_exponent), .out_fraction(out_fraction), .out_inf(out_inf), .out_zero(out_zero)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
  endtask

  function automatic exp_t model(input op_t a, input op_t b);
    exp_t e;
    longint unsigned ma, mb, p;
    int s;
    e.inf  = a.inf | b.inf;
    e.zero = !e.inf & (a.zero | b.zero);
    e.sign = 1'b0; e.scale = '0; e.frac = '0;
    if (!(e.inf | e.zero)) begin
      ma = 64'(27'h0) | (64'd1 << 27) | 64'(a.frac);
      mb = (64'd1 << 27) | 64'(b.frac);
      p  = ma * mb;
      s  = $signed(a.scale) + $signed(b.scale);
      if (p[55]) begin
        s = s + 1;
        e.frac = 56'(p << 1);
      end else begin
        e.frac = 56'(p << 2);
      end
`ifdef POSIT_PRODUCT_SAT_EN
      if (s > 120) begin s = 120; e.frac = '0; end
      else if (s < -120) begin s = -120; e.frac = '0; end
`endif
      e.sign  = a.sign ^ b.sign;
      e.scale = 9'(s);
    end
    return e;
  endfunction

  function automatic op_t mk(input logic s, input int sc, input logic [26:0] f,
                             input logic inf, input logic zero);
    op_t o;
    o.sign = s; o.scale = 8'(sc); o.frac = f; o.inf = inf; o.zero = zero;
    return o;
  endfunction

  function automatic op_t rand_op();
    return mk(1'($urandom), int'($urandom_range(0, 240)) - 120, 27'($urandom), 1'b0, 1'b0);
  endfunction

  task automatic drive(input op_t a, input op_t b);
    a_sign = a.sign; a_scale = a.scale; a_fraction = a.frac; a_inf = a.inf; a_zero = a.zero;
    b_sign = b.sign; b_scale = b.scale; b_fraction = b.frac; b_inf = b.inf; b_zero = b.zero;
  endtask

  // Offer one pair until accepted; returns #1 after the accepting edge
  task automatic send(input op_t a, input op_t b);
    int n;
    drive(a, b);
    in_valid = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!in_ready && n < 50);
    if (!in_ready) chk("send_timeout", 64'(n), 64'd0);
    else sb.push_back(model(a, b));
    @(posedge clk); #1;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 60) begin
      @(posedge clk); #1;
      n++;
    end
    chk("drain_left", 64'(sb.size()), 64'd0);
  endtask

  // Output monitor: compare each delivered product against the scoreboard head
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      xfer++;
      if (sb.size() == 0) begin
        chk("unexpected_out", 64'd1, 64'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("sign",     64'(out_sign),     64'(e.sign));
        chk("scale",    64'(out_scale),    64'(e.scale));
        chk("exponent", 64'(out_exponent), 64'(e.scale[1:0]));
        chk("fraction", 64'(out_fraction), 64'(e.frac));
        chk("inf",      64'(out_inf),      64'(e.inf));
        chk("zero",     64'(out_zero),     64'(e.zero));
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish (%0d/%0d)", n_pass, n_chk);
    $fatal(1);
  end

  initial begin
    op_t one, h10, hm3, nar, zro, m3, s120, q[6];
    int k, idx, x0;

    one  = mk(1'b0, 0, 27'h0, 1'b0, 1'b0);
    h10  = mk(1'b0, 10, 27'h4000000, 1'b0, 1'b0);
    hm3  = mk(1'b0, -3, 27'h4000000, 1'b0, 1'b0);
    nar  = mk(1'b0, 0, 27'h0, 1'b1, 1'b0);
    zro  = mk(1'b0, 0, 27'h0, 1'b0, 1'b1);
    m3   = mk(1'b1, 1, 27'h4000000, 1'b0, 1'b0);
    s120 = mk(1'b0, 120, 27'h0, 1'b0, 1'b0);

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    drive(one, one);
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_in_ready",  64'(in_ready),  64'd0);
    chk("rst_scale",     64'(out_scale), 64'd0);
    chk("rst_fraction",  64'(out_fraction), 64'd0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;

    // 1.0*1.0 and accept-to-valid latency
    send(one, one);
    in_valid = 1'b0;
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!out_valid && k < 20);
    chk("latency", 64'(k), 64'(LATENCY));
    @(posedge clk); #1;

    // Directed corner cases, back-to-back
    send(h10, hm3);
    send(nar, zro);
    send(zro, m3);
    send(nar, h10);
    send(m3, h10);
    send(s120, s120);
    send(mk(1'b0, -120, 27'h0, 1'b0, 1'b0), mk(1'b1, -120, 27'h7FFFFFF, 1'b0, 1'b0));
    send(mk(1'b0, 0, 27'h7FFFFFF, 1'b0, 1'b0), mk(1'b0, 0, 27'h7FFFFFF, 1'b0, 1'b0));
    in_valid = 1'b0;
    drain();

    // Stall: 6 offers against a blocked output
    for (int i = 0; i < 6; i++) q[i] = rand_op();
    out_ready = 1'b0;
    idx = 0;
    for (int c = 0; c < 10; c++) begin
      drive(q[idx], q[(idx + 3) % 6]);
      in_valid = 1'b1;
      @(negedge clk);
      if (in_ready) begin
        sb.push_back(model(q[idx], q[(idx + 3) % 6]));
        idx++;
      end
      @(posedge clk); #1;
    end
    chk("stall_accepted", 64'(idx), 64'd3);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("stall_in_ready", 64'(in_ready), 64'd0);
      chk("stall_valid",    64'(out_valid), 64'd1);
      chk("stall_fraction", 64'(out_fraction), 64'(sb[0].frac));
      chk("stall_scale",    64'(out_scale), 64'(sb[0].scale));
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    x0 = xfer;
    for (int c = 0; c < 6; c++) begin
      if (idx < 6) begin
        drive(q[idx], q[(idx + 3) % 6]);
        in_valid = 1'b1;
      end else begin
        in_valid = 1'b0;
      end
      @(negedge clk);
      if (in_valid && in_ready) begin
        sb.push_back(model(q[idx], q[(idx + 3) % 6]));
        idx++;
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    chk("release_accepted", 64'(idx), 64'd6);
    chk("release_rate", 64'(xfer - x0), 64'd6);
    drain();

    // Reset with two products in flight
    send(rand_op(), rand_op());
    send(rand_op(), rand_op());
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", 64'(out_valid), 64'd0);
    chk("midrst_in_ready",  64'(in_ready),  64'd0);
    sb.delete();
    @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    k = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (out_valid) k++;
    end
    chk("no_stale_out", 64'(k), 64'd0);
    @(posedge clk); #1;

    // Recovery plus random traffic
    for (int i = 0; i < 10; i++) send(rand_op(), rand_op());
    in_valid = 1'b0;
    drain();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
